// File: rtl/cnn_pool_stream.sv
// Streaming KxK non-overlapping max/avg pooling with optional ReLU over a raster feature map.
// One-cycle latency from window-completing beat to out_valid; in_ready drops while the output is stalled or draining.
module cnn_pool_stream #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 3,
    parameter int IN_W   = 4,
    parameter int IN_H   = 4,
    parameter int POOL_K = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mode,
    input  logic                     relu_en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     out_last,
    output logic                     done
);
    localparam int OUT_W = IN_W / POOL_K;
    localparam int OUT_H = IN_H / POOL_K;
    localparam int LOG_K = $clog2(POOL_K);
    localparam int SH    = 2 * LOG_K;
    localparam int AW    = DATA_W + SH;
    localparam int CW    = $clog2(IN_W + 1);
    localparam int RW    = $clog2(IN_H + 1);
    localparam int IW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    localparam logic [CW-1:0] C_COL_LAST = CW'(IN_W - 1);
    localparam logic [CW-1:0] C_K_LAST   = CW'(POOL_K - 1);
    localparam logic [CW-1:0] C_OW       = CW'(OUT_W);
    localparam logic [CW-1:0] C_OW_LAST  = CW'(OUT_W - 1);
    localparam logic [RW-1:0] R_ROW_LAST = RW'(IN_H - 1);
    localparam logic [RW-1:0] R_K_LAST   = RW'(POOL_K - 1);
    localparam logic [RW-1:0] R_OH       = RW'(OUT_H);
    localparam logic [RW-1:0] R_OH_LAST  = RW'(OUT_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                     r_state, w_state_nxt;
    logic                       w_done_nxt;
    logic [CW-1:0]              r_col, r_kx, r_wx;
    logic [RW-1:0]              r_row, r_ky, r_wy;
    logic                       r_mode, r_relu, r_done;
    logic                       r_out_vld, r_out_last;
    logic [NUM_CH*DATA_W-1:0]   r_out_dat;
    logic signed [AW-1:0]       r_acc [OUT_W][NUM_CH];

    logic                       w_acc, w_pend, w_in_win, w_first, w_last;
    logic                       w_col_end, w_frame_end, w_win_last, w_mode, w_relu;
    logic [IW-1:0]              w_idx;
    logic signed [AW-1:0]       w_comb [NUM_CH];
    logic [NUM_CH*DATA_W-1:0]   w_fin;

    assign in_ready    = !reset && (r_state != S_DRAIN) && (!r_out_vld || out_ready);
    assign w_acc       = in_valid && in_ready;
    assign w_pend      = r_out_vld && !out_ready;
    assign w_in_win    = (r_wx < C_OW) && (r_wy < R_OH);
    assign w_first     = (r_kx == '0) && (r_ky == '0);
    assign w_last      = (r_kx == C_K_LAST) && (r_ky == R_K_LAST);
    assign w_col_end   = (r_col == C_COL_LAST);
    assign w_frame_end = w_col_end && (r_row == R_ROW_LAST);
    assign w_win_last  = (r_wx == C_OW_LAST) && (r_wy == R_OH_LAST);
    assign w_idx       = r_wx[IW-1:0];
    // The first beat of a frame uses the live mode pins; later beats use the latched copy.
    assign w_mode      = (r_state == S_IDLE) ? mode    : r_mode;
    assign w_relu      = (r_state == S_IDLE) ? relu_en : r_relu;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic signed [DATA_W-1:0] w_pix;
        logic signed [AW-1:0]     w_ext, w_old, w_sh;
        assign w_pix     = in_data[c*DATA_W +: DATA_W];
        assign w_ext     = AW'(w_pix);
        assign w_old     = r_acc[w_idx][c];
        assign w_comb[c] = w_first ? w_ext :
                           w_mode  ? (w_old + w_ext) :
                           ((w_ext > w_old) ? w_ext : w_old);
        assign w_sh      = w_mode ? (w_comb[c] >>> SH) : w_comb[c];
        assign w_fin[c*DATA_W +: DATA_W] = (w_relu && w_sh[DATA_W-1]) ? '0 : w_sh[DATA_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col <= '0; r_kx <= '0; r_wx <= '0;
            r_row <= '0; r_ky <= '0; r_wy <= '0;
        end else if (w_acc) begin
            if (w_col_end) begin
                r_col <= '0; r_kx <= '0; r_wx <= '0;
                if (w_frame_end) begin
                    r_row <= '0; r_ky <= '0; r_wy <= '0;
                end else begin
                    r_row <= r_row + 1'b1;
                    if (r_ky == R_K_LAST) begin
                        r_ky <= '0;
                        r_wy <= r_wy + 1'b1;
                    end else begin
                        r_ky <= r_ky + 1'b1;
                    end
                end
            end else begin
                r_col <= r_col + 1'b1;
                if (r_kx == C_K_LAST) begin
                    r_kx <= '0;
                    r_wx <= r_wx + 1'b1;
                end else begin
                    r_kx <= r_kx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < OUT_W; i++)
                for (int c = 0; c < NUM_CH; c++)
                    r_acc[i][c] <= '0;
        end else if (w_acc && w_in_win) begin
            for (int c = 0; c < NUM_CH; c++)
                r_acc[w_idx][c] <= w_comb[c];
        end
    end

    // Output slot refills in the same cycle it drains, so windows can stream back to back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_vld  <= 1'b0;
            r_out_dat  <= '0;
            r_out_last <= 1'b0;
        end else if (w_acc && w_in_win && w_last) begin
            r_out_vld  <= 1'b1;
            r_out_dat  <= w_fin;
            r_out_last <= w_win_last;
        end else if (out_ready) begin
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_relu  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            if (r_state == S_IDLE && w_acc) begin
                r_mode <= mode;
                r_relu <= relu_en;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE:  if (w_acc) w_state_nxt = w_frame_end ? S_DRAIN : S_RUN;
            S_RUN:   if (w_acc && w_frame_end) w_state_nxt = S_DRAIN;
            S_DRAIN: if (!w_pend) begin
                         w_state_nxt = S_IDLE;
                         w_done_nxt  = 1'b1;
                     end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign out_valid = r_out_vld;
    assign out_data  = r_out_dat;
    assign out_last  = r_out_last;
    assign done      = r_done;
endmodule

// File: tb/tb_cnn_pool_stream.sv
// Scoreboard bench for cnn_pool_stream: a 4x4 and a 5x5 instance, max/avg, ReLU, stall and reset-abort.
module tb_cnn_pool_stream;
    localparam int DW = 16;
    localparam int NC = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mode = 1'b0, relu_en = 1'b0, in_valid = 1'b0, out_ready = 1'b1, sel = 1'b0;
    logic [NC*DW-1:0] in_data = '0;

    logic in_rdy4, ovld4, olast4, done4, in_rdy5, ovld5, olast5, done5;
    logic [NC*DW-1:0] odat4, odat5;
    logic in_vld4, in_vld5;
    logic w_in_rdy, w_ovld, w_olast, w_done;
    logic [NC*DW-1:0] w_odat;

    assign in_vld4  = in_valid && !sel;
    assign in_vld5  = in_valid && sel;
    assign w_in_rdy = sel ? in_rdy5 : in_rdy4;
    assign w_ovld   = sel ? ovld5   : ovld4;
    assign w_olast  = sel ? olast5  : olast4;
    assign w_done   = sel ? done5   : done4;
    assign w_odat   = sel ? odat5   : odat4;

    cnn_pool_stream #(.DATA_W(DW), .NUM_CH(NC), .IN_W(4), .IN_H(4), .POOL_K(2)) dut4 (
        .clk(clk), .reset(reset), .mode(mode), .relu_en(relu_en),
        .in_valid(in_vld4), .in_ready(in_rdy4), .in_data(in_data),
        .out_valid(ovld4), .out_ready(out_ready), .out_data(odat4),
        .out_last(olast4), .done(done4));

    cnn_pool_stream #(.DATA_W(DW), .NUM_CH(NC), .IN_W(5), .IN_H(5), .POOL_K(2)) dut5 (
        .clk(clk), .reset(reset), .mode(mode), .relu_en(relu_en),
        .in_valid(in_vld5), .in_ready(in_rdy5), .in_data(in_data),
        .out_valid(ovld5), .out_ready(out_ready), .out_data(odat5),
        .out_last(olast5), .done(done5));

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int cyc = 0, hs_cyc = 0, done_cyc = 0, last_beat_cyc = 0, done_cnt = 0;
    logic [NC*DW:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pv(input int ch, input int r, input int c, input int w);
        case (ch)
            0:       return r * w + c;
            1:       return -(r * w + c);
            default: return c * 5 - r * 7;
        endcase
    endfunction

    task automatic gen_expect(input int w, input int h, input bit m, input bit rl);
        logic [NC*DW:0] e;
        int ow = w / 2, oh = h / 2;
        for (int wy = 0; wy < oh; wy++)
            for (int wx = 0; wx < ow; wx++) begin
                e = '0;
                for (int ch = 0; ch < NC; ch++) begin
                    int mx = -100000, sm = 0, res, v;
                    for (int dy = 0; dy < 2; dy++)
                        for (int dx = 0; dx < 2; dx++) begin
                            v = pv(ch, wy * 2 + dy, wx * 2 + dx, w);
                            sm += v;
                            if (v > mx) mx = v;
                        end
                    res = m ? (sm >>> 2) : mx;
                    if (rl && res < 0) res = 0;
                    e[ch*DW +: DW] = res[DW-1:0];
                end
                e[NC*DW] = (wy == oh - 1) && (wx == ow - 1);
                exp_q.push_back(e);
            end
    endtask

    always @(negedge clk) begin
        logic [NC*DW:0] e;
        if (!reset && w_ovld && out_ready) begin
            hs_cyc = cyc;
            chk("out_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_data", w_odat, e[NC*DW-1:0]);
                chk("out_last", w_olast, e[NC*DW]);
            end
        end
        if (w_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic send_beat(input int r, input int c, input int w);
        int n = 0;
        in_valid = 1'b1;
        for (int ch = 0; ch < NC; ch++) begin
            int v = pv(ch, r, c, w);
            in_data[ch*DW +: DW] = v[DW-1:0];
        end
        forever begin
            @(negedge clk);
            if (w_in_rdy) break;
            if (++n > 200) begin
                chk("in_ready_wait", w_in_rdy, 1);
                break;
            end
        end
        last_beat_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic stall_first();
        int n = 0;
        while (!w_ovld && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", w_ovld, 1);
            chk("stall_data", w_odat[DW-1:0], 5);
            chk("stall_in_ready", w_in_rdy, 0);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
    endtask

    task automatic run_frame(input int w, input int h, input bit m, input bit rl,
                             input bit flip, input bit stall);
        int d0 = done_cnt;
        int n = 0;
        gen_expect(w, h, m, rl);
        mode = m;
        relu_en = rl;
        if (stall) out_ready = 1'b0;
        fork
            begin
                for (int r = 0; r < h; r++)
                    for (int c = 0; c < w; c++) begin
                        send_beat(r, c, w);
                        if (flip) mode = ~m;
                    end
            end
            if (stall) stall_first();
        join
        while (done_cnt == d0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("done_count", done_cnt - d0, 1);
        chk("queue_drained", exp_q.size(), 0);
        if (w == 4) chk("done_after_hs", done_cyc - hs_cyc, 1);
        else        chk("done_after_beat", done_cyc - last_beat_cyc, 2);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d_before;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", w_in_rdy, 0);
        chk("rst_out_valid", w_ovld, 0);
        chk("rst_out_data", w_odat, 0);
        chk("rst_out_last", w_olast, 0);
        chk("rst_done", w_done, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", w_in_rdy, 1);
        @(posedge clk);
        #1;

        run_frame(4, 4, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(4, 4, 1'b1, 1'b0, 1'b1, 1'b0);
        run_frame(4, 4, 1'b0, 1'b1, 1'b0, 1'b0);
        run_frame(4, 4, 1'b1, 1'b1, 1'b0, 1'b0);
        run_frame(4, 4, 1'b0, 1'b0, 1'b0, 1'b1);

        sel = 1'b1;
        run_frame(5, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        sel = 1'b0;

        d_before = done_cnt;
        gen_expect(4, 4, 1'b0, 1'b0);
        mode = 1'b0;
        relu_en = 1'b0;
        for (int i = 0; i < 7; i++) send_beat(i / 4, i % 4, 4);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("abort_in_ready", w_in_rdy, 0);
        chk("abort_out_valid", w_ovld, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_no_done", done_cnt - d_before, 0);
        chk("abort_idle_valid", w_ovld, 0);
        @(posedge clk);
        #1;
        run_frame(4, 4, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cnn_pool_stream.md
# cnn_pool_stream

Streaming, parametrised K×K pooling stage for the CNN datapath: it consumes a convolution feature map in raster order, one pixel per beat carrying all channels in parallel, and emits pooled pixels over a valid/ready stream. It replaces the fixed 2×2 max-pool of the monolithic CNN top. New in this generation:
- configurable window;
- max or average mode;
- optional ReLU;
- back-pressure;
- a per-frame `done` pulse.

## Interface
- `DATA_W`, 16: signed pixel width per channel.
- `NUM_CH`, 3: channels per beat (one per filter).
- `IN_W`, 4: input feature-map width.
- `IN_H`, 4: input feature-map height.
- `POOL_K`, 2: window size and stride (non-overlapping). Must be a power of 2 if avg mode is used.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `mode` input 1: 0 = max, 1 = average; sampled on the first beat of a frame.
- `relu_en` input 1: clamp negative results to 0; sampled with `mode`.
- `in_valid` input 1: input beat valid.
- `in_ready` output 1: input beat accepted when `in_valid && in_ready`.
- `in_data` input NUM_CH*DATA_W: channel c in bits [c*DATA_W +: DATA_W].
- `out_valid` output 1: pooled beat valid.
- `out_ready` input 1: downstream accepts.
- `out_data` output NUM_CH*DATA_W: pooled channels, same packing as `in_data`.
- `out_last` output 1: marks the final pooled beat of a frame.
- `done` output 1: one-cycle pulse at frame completion.

## Operation
- Output dimensions: OUT_W = IN_W/POOL_K, OUT_H = IN_H/POOL_K (floor). Pixels in trailing columns/rows outside whole windows are accepted and discarded.
- Counters `col` (0..IN_W-1) and `row` (0..IN_H-1) advance on each accepted beat. `col` wraps to 0 with `row` incrementing; `row` wraps to 0 at frame end.
- Row accumulator buffer: OUT_W entries × NUM_CH, each ACC_W = DATA_W + 2*clog2(POOL_K) bits, signed.
- On the first pixel of a window (row%K==0 and col%K==0), the entry is loaded with the sign-extended pixel. On every other pixel of the window, it is combined with the pixel: signed max, or sum.
- On the last pixel of a window (row%K==K-1 and col%K==K-1), the combined value is finalised:
  - max: take the low DATA_W bits;
  - avg: arithmetic right shift by log2(K*K), rounding toward −∞, then take the low DATA_W bits;
  - then, if relu_en, replace negative values with 0.
- The finalised value loads the output register.
- `mode` and `relu_en` are latched on the frame's first accepted beat and hold until `done`.
- FSM states:
  - IDLE: no beat of the frame yet; IDLE→RUN on the first accepted beat.
  - RUN: RUN→DRAIN on accepting the beat at (IN_H-1, IN_W-1).
  - DRAIN: waits until no output is pending, then →IDLE with `done`=1 for that one cycle.
- `in_ready` = (state != DRAIN) && (!out_valid || out_ready).
- `out_last` = 1 on the beat for window (OUT_H-1, OUT_W-1).

## Timing
- Reset values: `in_ready`=0 during reset, 1 in the first cycle after release; `out_valid`=0, `out_data`=0, `out_last`=0, `done`=0. FSM=IDLE, counters=0, accumulators=0.
- Latency: `out_valid` rises the cycle after the window-completing beat is accepted.
- `out_data` and `out_last` hold stable while `out_valid && !out_ready`.
- The output register can be refilled in the same cycle it drains: `out_ready`=1 with a completing beat gives a back-to-back output.
- `done` fires one cycle after the last output handshake. If no output is pending when DRAIN is entered, it fires one cycle after DRAIN entry. Minimum gap from the last input beat to `done` is 2 cycles.
- Reset mid-frame aborts the frame immediately: no `done`, pending output dropped, the next beat starts a new frame.
- `in_valid` with `in_ready`=0 has no effect. The producer holds its data.

## Test plan
- Max mode, default parameters, channel 0 pixel = row*4+col, no stalls -> out_data ch0 sequence 5, 7, 13, 15; `out_last` on the 4th output; `done` pulse 1 cycle after the 4th handshake.
- Avg mode, same stimulus -> ch0 sequence 2, 4, 10, 12.
- Channel 1 = −(row*4+col):
  - max, relu_en=0 -> 0, −2, −8, −10;
  - max, relu_en=1 -> 0, 0, 0, 0;
  - avg, relu_en=0 -> −3, −5, −11, −13.
- Back-pressure: `out_ready`=0 for 5 cycles at the first output -> `out_valid` and value 5 held stable; `in_ready`=0 throughout; no beat lost; full sequence is unchanged.
- Instance with IN_W=IN_H=5, pixel = row*5+col, max -> 6, 8, 16, 18. All 25 beats are accepted, and `done` follows the 25th beat.
- Assert `reset` after the 7th beat, then send a full frame with `mode` toggled -> no stale output, the new mode is used, and exactly one `done`.
